mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter CALC_CYCLES, default 2: cycles operands are held on the multiplier before capture (legal 1..15).
REQ-002 SHALL have parameter TAG_W, default 4: requester tag width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request can be accepted this cycle.
REQ-008 req_op  input  2  00 MUL (low, s×s), 01 MULH (high, s×s), 10 MULHSU (high, s×u), 11 MULHU (high, u×u).
REQ-009 req_a, req_b  input  32 each  operands.
REQ-010 req_tag  input  TAG_W  returned unchanged with the result.
REQ-011 resp_valid  output  1; resp_ready  input  1; resp_data  output  32; resp_tag  output  TAG_W.
REQ-012 mul_s1, mul_s2  output  1 each; mul_in1, mul_in2  output  32 each  drive the external combinational 32x32 multiplier.
REQ-013 mul_out  input  64  multiplier product.

Function
REQ-014 SHALL implement FSM IDLE, CALC, DONE.
REQ-015 req_ready SHALL be 1 in IDLE, and in DONE when resp_ready=1; 0 otherwise.
REQ-016 On req_valid&req_ready: register a, b, op, tag; set s1/s2 from op (MUL 1/1, MULH 1/1, MULHSU 1/0, MULHU 0/0); load counter CALC_CYCLES-1; enter CALC.
REQ-017 mul_in1/in2/s1/s2 SHALL come only from registers, stable from the cycle after acceptance until the next acceptance.
REQ-018 CALC: counter decrements each cycle; at counter 0, capture mul_out into a 64-bit product register and enter DONE.
REQ-019 Latency: acceptance at edge 0 -> resp_valid high from cycle CALC_CYCLES+1.
REQ-020 resp_data SHALL be product[31:0] for MUL, product[63:32] for other ops.
REQ-021 DONE: resp_valid=1; resp_data and resp_tag held stable until resp_ready=1.
REQ-022 DONE with resp_ready=1 and req_valid=1: complete and accept in the same cycle, go directly to CALC (back-to-back, no IDLE bubble).
REQ-023 DONE with resp_ready=1 and req_valid=0: go to IDLE, resp_valid=0 next cycle.
REQ-024 req_valid SHALL be ignored in CALC; no request is lost or duplicated.

Reset
REQ-025 rst=1 SHALL force IDLE, resp_valid=0, resp_data=0, resp_tag=0, mul_in1/in2=0, mul_s1/s2=0, counter=0, product=0, reuse-valid=0.
REQ-026 rst during CALC or DONE SHALL abort the operation with no response; req_ready=1 in the first cycle after rst is released.

Configuration
REQ-027 Macro MUL_REUSE_EN compiles in product reuse.
REQ-028 With MUL_REUSE_EN: keep last captured a, b, s1, s2 and a reuse-valid flag; an accepted request whose a, b match and (op=MUL or s1/s2 match) SHALL skip CALC, enter DONE, resp_valid in cycle 1.
REQ-029 Without MUL_REUSE_EN: every request goes through CALC; no reuse registers exist.

Structure
REQ-030 Shared package mul_ctrl_pkg SHALL hold op encodings, FSM state encodings, and default CALC_CYCLES.
REQ-031 One sub-module mul_op_decode (op -> s1, s2, high-half select) is natural; the multiplier itself is outside this block.

Verification
REQ-032 MULHU a=0xFFFFFFFF b=0xFFFFFFFF, CALC_CYCLES=2 -> resp_data=0xFFFFFFFE, resp_valid in cycle 3.
REQ-033 MULH a=0xFFFFFFFF b=0x00000002 -> 0xFFFFFFFF; MUL same operands -> 0xFFFFFFFE.
REQ-034 MULHSU a=0x80000000 b=0xFFFFFFFF -> 0x80000000, resp_tag equals req_tag.
REQ-035 resp_ready=0 for 5 cycles -> resp_valid/data/tag held, req_ready=0; then resp_ready=1 with req_valid=1 -> new request accepted that cycle.
REQ-036 rst asserted in CALC -> no resp_valid, req_ready=1 after release.
REQ-037 MULH 0x12345678×0x9ABCDEF0 then MUL same operands -> with MUL_REUSE_EN second resp_valid in cycle 1 after accept; without it in cycle CALC_CYCLES+1; data matches reference model.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - op encodings, FSM states and defaults for the sequential multiplier controller.
package mul_ctrl_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   localparam int CALC_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/mul_op_decode.sv
// rtl/mul_op_decode.sv - maps a multiply op to operand signedness and result half select.
module mul_op_decode
   import mul_ctrl_pkg::*;
(
   input  logic [1:0] op,
   output logic       s1,
   output logic       s2,
   output logic       hi_sel
);

   always_comb begin
      s1     = 1'b1;
      s2     = 1'b1;
      hi_sel = 1'b1;
      case (op)
         OP_MUL:    hi_sel = 1'b0;
         OP_MULH:   ;
         OP_MULHSU: s2 = 1'b0;
         default: begin
            s1 = 1'b0;
            s2 = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - request/response sequencer around an external 32x32 combinational multiplier.
// Define MUL_REUSE_EN to answer repeated operand pairs straight from the last captured product.
module mul_seq_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int CALC_CYCLES = CALC_CYCLES_DEF,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             mul_s1,
   output logic             mul_s2,
   output logic [31:0]      mul_in1,
   output logic [31:0]      mul_in2,
   input  logic [63:0]      mul_out
);

   localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

   logic dec_s1, dec_s2, dec_hi;

   mul_op_decode u_dec (
      .op     (req_op),
      .s1     (dec_s1),
      .s2     (dec_s2),
      .hi_sel (dec_hi)
   );

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      in1_q, in1_d, in2_q, in2_d;
   logic             s1_q, s1_d, s2_q, s2_d;
   logic             hi_q, hi_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [63:0]      product_q, product_d;
   logic             resp_valid_q, resp_valid_d;
   logic             accept;
   logic             reuse_hit;

`ifdef MUL_REUSE_EN
   // The operand registers double as the record of what product_q holds.
   logic reuse_valid_q, reuse_valid_d;
   assign reuse_hit = reuse_valid_q && (req_a == in1_q) && (req_b == in2_q) &&
                      ((req_op == OP_MUL) || ((dec_s1 == s1_q) && (dec_s2 == s2_q)));
`else
   assign reuse_hit = 1'b0;
`endif

   assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in1_d     = in1_q;
      in2_d     = in2_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      hi_d      = hi_q;
      tag_d     = tag_q;
      product_d = product_q;
`ifdef MUL_REUSE_EN
      reuse_valid_d = reuse_valid_q;
`endif
      case (state_q)
         ST_CALC: begin
            if (cnt_q == 4'd0) begin
               product_d = mul_out;
               state_d   = ST_DONE;
`ifdef MUL_REUSE_EN
               reuse_valid_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: if (resp_ready) state_d = ST_IDLE;
         default: ;
      endcase
      if (accept) begin
         tag_d = req_tag;
         hi_d  = dec_hi;
         if (reuse_hit) begin
            state_d = ST_DONE;
         end else begin
            in1_d   = req_a;
            in2_d   = req_b;
            s1_d    = dec_s1;
            s2_d    = dec_s2;
            cnt_d   = CNT_LOAD;
            state_d = ST_CALC;
`ifdef MUL_REUSE_EN
            reuse_valid_d = 1'b0;
`endif
         end
      end
      resp_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         in1_q        <= 32'd0;
         in2_q        <= 32'd0;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         hi_q         <= 1'b0;
         tag_q        <= '0;
         product_q    <= 64'd0;
         resp_valid_q <= 1'b0;
`ifdef MUL_REUSE_EN
         reuse_valid_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         hi_q         <= hi_d;
         tag_q        <= tag_d;
         product_q    <= product_d;
         resp_valid_q <= resp_valid_d;
`ifdef MUL_REUSE_EN
         reuse_valid_q <= reuse_valid_d;
`endif
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = hi_q ? product_q[63:32] : product_q[31:0];
   assign resp_tag   = tag_q;
   assign mul_in1    = in1_q;
   assign mul_in2    = in2_q;
   assign mul_s1     = s1_q;
   assign mul_s2     = s2_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed and randomized checks of mul_seq_ctrl against a reference model.
module tb_mul_seq_ctrl;

   localparam int CC = 2;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [31:0]   req_a, req_b;
   logic [TW-1:0] req_tag;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_data;
   logic [TW-1:0] resp_tag;
   logic          mul_s1, mul_s2;
   logic [31:0]   mul_in1, mul_in2;
   logic [63:0]   mul_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic        m_rv;
   logic [31:0] m_a, m_b;
   logic        m_s1, m_s2;

   always #5 clk = ~clk;

   // Stand-in for the external combinational multiplier.
   logic [63:0] ext1, ext2;
   assign ext1    = mul_s1 ? {{32{mul_in1[31]}}, mul_in1} : {32'd0, mul_in1};
   assign ext2    = mul_s2 ? {{32{mul_in2[31]}}, mul_in2} : {32'd0, mul_in2};
   assign mul_out = ext1 * ext2;

   mul_seq_ctrl #(.CALC_CYCLES(CC), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_tag   (resp_tag),
      .mul_s1     (mul_s1),
      .mul_s2     (mul_s2),
      .mul_in1    (mul_in1),
      .mul_in2    (mul_in2),
      .mul_out    (mul_out)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = (op != 2'b11) ? longint'($signed(a)) : longint'({32'd0, a});
      sb = (op[1] == 1'b0) ? longint'($signed(b)) : longint'({32'd0, b});
      p  = 64'(sa * sb);
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic model_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
      logic s1, s2;
      bit hit;
      s1  = (op != 2'b11);
      s2  = !op[1];
      hit = 1'b0;
`ifdef MUL_REUSE_EN
      hit = m_rv && (a == m_a) && (b == m_b) && ((op == 2'b00) || ((s1 == m_s1) && (s2 == m_s2)));
`endif
      if (hit) begin
         lat = 1;
      end else begin
         lat  = CC + 1;
         m_a  = a;
         m_b  = b;
         m_s1 = s1;
         m_s2 = s2;
         m_rv = 1'b1;
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
      @(negedge clk);
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      req_tag    = tag;
      #1;
      chk("req_ready_at_issue", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int lat, input logic [31:0] exp, input logic [TW-1:0] tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      chk("resp_latency", 64'(n), 64'(lat));
      chk("resp_data", 64'(resp_data), 64'(exp));
      chk("resp_tag", 64'(resp_tag), 64'(tag));
      chk("mul_in1", 64'(mul_in1), 64'(m_a));
      chk("mul_in2", 64'(mul_in2), 64'(m_b));
      chk("mul_s1", 64'(mul_s1), 64'(m_s1));
      chk("mul_s2", 64'(mul_s2), 64'(m_s2));
   endtask

   task automatic transact(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tag, input logic [31:0] exp);
      int lat;
      issue(op, a, b, tag);
      model_accept(op, a, b, lat);
      wait_resp(lat, exp, tag);
   endtask

   initial begin
      logic [31:0] corner [5];
      logic [31:0] a, b, exp;
      logic [1:0]  op;
      int          lat;
      bit          seen;

      corner[0] = 32'h0000_0000;
      corner[1] = 32'h0000_0001;
      corner[2] = 32'h7FFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'hFFFF_FFFF;
      m_rv = 1'b0; m_a = '0; m_b = '0; m_s1 = 1'b0; m_s2 = 1'b0;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      req_op = 2'b00; req_a = '0; req_b = '0; req_tag = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", 64'(resp_data), 64'd0);
      chk("rst_resp_tag", 64'(resp_tag), 64'd0);
      chk("rst_mul_in1", 64'(mul_in1), 64'd0);
      chk("rst_mul_in2", 64'(mul_in2), 64'd0);
      chk("rst_mul_s", 64'({mul_s1, mul_s2}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      transact(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_FFFE);
      transact(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 4'h7, 32'hFFFF_FFFF);
      transact(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 4'h8, 32'hFFFF_FFFE);
      transact(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA, 32'h8000_0000);

      // Response backpressure, then a same-cycle complete-and-accept.
      exp = ref_result(2'b01, 32'h0BAD_F00D, 32'hC0DE_1234);
      issue(2'b01, 32'h0BAD_F00D, 32'hC0DE_1234, 4'h5);
      resp_ready = 1'b0;
      model_accept(2'b01, 32'h0BAD_F00D, 32'hC0DE_1234, lat);
      wait_resp(lat, exp, 4'h5);
      repeat (5) begin
         @(negedge clk);
         chk("stall_resp_valid", 64'(resp_valid), 64'd1);
         chk("stall_resp_data", 64'(resp_data), 64'(exp));
         chk("stall_resp_tag", 64'(resp_tag), 64'h5);
         chk("stall_req_ready", 64'(req_ready), 64'd0);
      end
      issue(2'b00, 32'h1357_9BDF, 32'h2468_ACE0, 4'h6);
      model_accept(2'b00, 32'h1357_9BDF, 32'h2468_ACE0, lat);
      wait_resp(lat, ref_result(2'b00, 32'h1357_9BDF, 32'h2468_ACE0), 4'h6);

      // Reset in the middle of a calculation.
      issue(2'b01, 32'hDEAD_BEEF, 32'h0123_4567, 4'h9);
      model_accept(2'b01, 32'hDEAD_BEEF, 32'h0123_4567, lat);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_rv = 1'b0; m_a = '0; m_b = '0; m_s1 = 1'b0; m_s2 = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", 64'(req_ready), 64'd1);
      chk("abort_resp_valid", 64'(resp_valid), 64'd0);
      chk("abort_resp_data", 64'(resp_data), 64'd0);
      chk("abort_resp_tag", 64'(resp_tag), 64'd0);
      chk("abort_mul_in1", 64'(mul_in1), 64'd0);
      chk("abort_mul_s", 64'({mul_s1, mul_s2}), 64'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("abort_no_resp", 64'(seen), 64'd0);

      transact(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 4'hB, ref_result(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
      transact(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 4'hC, ref_result(2'b00, 32'h1234_5678, 32'h9ABC_DEF0));
      transact(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 4'hD, ref_result(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));

      a = 32'h5555_AAAA;
      b = 32'h0F0F_F0F0;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: ;
            1: begin a = $urandom; b = $urandom; end
            2: begin a = corner[$urandom_range(0, 4)]; b = corner[$urandom_range(0, 4)]; end
            default: b = $urandom;
         endcase
         transact(op, a, b, 4'($urandom), ref_result(op, a, b));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
